// File: rtl/shift_register_pkg.sv
// Shared constants and helpers for the shift_register block.
//
// Contents:
//   MIN_DEPTH / MAX_DEPTH : legal bounds for the DEPTH parameter
//   depth_in_range()      : elaboration-time legality check for DEPTH
package shift_register_pkg;

  localparam int unsigned MIN_DEPTH = 1;
  localparam int unsigned MAX_DEPTH = 1024;

  function automatic bit depth_in_range(input int unsigned depth);
    return (depth >= MIN_DEPTH) && (depth <= MAX_DEPTH);
  endfunction

endpackage

// File: rtl/shift_stage.sv
// One bit of the shift chain: a D flop with clock enable and an
// asynchronous, active-high clear.
//
// Ports:
//   clk : rising-edge clock
//   rst : asynchronous active-high clear (q -> 0 immediately)
//   en  : load d on the rising edge only when high; otherwise hold
//   d   : data in
//   q   : registered data out
module shift_stage (
  input  logic clk,
  input  logic rst,
  input  logic en,
  input  logic d,
  output logic q
);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      q <= 1'b0;
    end else if (en) begin
      q <= d;
    end
  end

endmodule

// File: rtl/shift_register.sv
// Serial-in / serial-out shift register with clock enable.
// A bit captured on SI at an enabled edge appears on SO after DEPTH-1
// further enabled edges; disabled edges freeze the whole chain.
//
// Parameters:
//   DEPTH : number of stages, 1..1024
//
// Ports:
//   clk   : sole clock, rising edge
//   rst   : asynchronous active-high reset, clears every stage
//   clken : shift enable, sampled on the rising edge
//   SI    : serial data in
//   SO    : serial data out, driven straight from the last stage flop
module shift_register
  import shift_register_pkg::*;
#(
  parameter int unsigned DEPTH = 8
) (
  input  logic clk,
  input  logic rst,
  input  logic clken,
  input  logic SI,
  output logic SO
);

  // Reject an out-of-range DEPTH while elaborating rather than building
  // a chain with zero (or an absurd number of) stages.
  if (!depth_in_range(DEPTH)) begin : g_depth_check
    $error("shift_register: DEPTH=%0d outside legal range", DEPTH);
  end

  // stage[0] is the input end, stage[DEPTH-1] drives SO.
  logic [DEPTH-1:0] stage;

  for (genvar gi = 0; gi < DEPTH; gi++) begin : g_stage
    if (gi == 0) begin : g_head
      shift_stage u_stage (
        .clk (clk),
        .rst (rst),
        .en  (clken),
        .d   (SI),
        .q   (stage[gi])
      );
    end else begin : g_body
      shift_stage u_stage (
        .clk (clk),
        .rst (rst),
        .en  (clken),
        .d   (stage[gi-1]),
        .q   (stage[gi])
      );
    end
  end

  // No logic between the last flop and the pin: SO has no
  // combinational path from SI or clken.
  assign SO = stage[DEPTH-1];

endmodule

// File: tb/tb_shift_register.sv
module tb_shift_register;

  logic clk = 1'b0;
  logic rst;
  logic clken;
  logic SI;
  logic so8;
  logic so1;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  shift_register #(.DEPTH(8)) u_dut8 (
    .clk   (clk),
    .rst   (rst),
    .clken (clken),
    .SI    (SI),
    .SO    (so8)
  );

  shift_register #(.DEPTH(1)) u_dut1 (
    .clk   (clk),
    .rst   (rst),
    .clken (clken),
    .SI    (SI),
    .SO    (so1)
  );

  // Drive inputs on the falling edge, then sample 1 time unit after the
  // following rising edge.
  task automatic step(input logic si, input logic en);
    @(negedge clk);
    SI    = si;
    clken = en;
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic obs, input logic exp);
    checks++;
    $display("t=%0t %s observed=%b expected=%b", $time, tag, obs, exp);
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%b expected=%b", tag, obs, exp);
    end
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog expired");
  end

  initial begin
    logic [0:15] pat_si;
    logic [0:15] pat_ex;
    logic [0:16] g_si;
    logic [0:16] g_en;
    logic [0:16] g_ex;

    // ---------------- reset ----------------
    rst   = 1'b1;
    clken = 1'b0;
    SI    = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    check("reset_so8", so8, 1'b0);
    check("reset_so1", so1, 1'b0);
    @(negedge clk);
    rst = 1'b0;
    for (int i = 0; i < 10; i++) begin
      step(1'b0, 1'b1);
      check($sformatf("idle_after_reset[%0d]", i), so8, 1'b0);
    end

    // ---------------- pattern 1,0,1,1,0,1,0 then zeros ----------------
    // First bit captured at edge 1 reaches SO after edge 8.
    pat_si = 16'b1011010_000000000;
    pat_ex = 16'b0000000_1011010_00;
    for (int i = 0; i < 16; i++) begin
      step(pat_si[i], 1'b1);
      check($sformatf("pattern[%0d]", i), so8, pat_ex[i]);
    end

    // ---------------- enable gating ----------------
    // 1,1,0,1 in; 5 frozen cycles with SI toggling; 8 enabled zeros.
    // Enabled edges 8..11 must then deliver 1,1,0,1 exactly.
    g_si = 17'b1101_10101_00000000;
    g_en = 17'b1111_00000_11111111;
    g_ex = 17'b0000_00000_00011010;
    for (int i = 0; i < 17; i++) begin
      step(g_si[i], g_en[i]);
      check($sformatf("gating[%0d]", i), so8, g_ex[i]);
    end

    // ---------------- reset mid-stream ----------------
    for (int i = 0; i < 8; i++) begin
      step(1'b1, 1'b1);
    end
    check("ones_loaded", so8, 1'b1);
    #1 rst = 1'b1;   // between edges
    #1;
    check("async_reset_drop", so8, 1'b0);
    #1 rst = 1'b0;
    for (int i = 0; i < 8; i++) begin
      step(1'b0, 1'b1);
      check($sformatf("after_midreset[%0d]", i), so8, 1'b0);
    end

    // ---------------- reset priority over clken ----------------
    @(negedge clk);
    rst = 1'b1;
    for (int i = 0; i < 3; i++) begin
      step(1'b1, 1'b1);
      check($sformatf("priority_rst[%0d]", i), so8, 1'b0);
    end
    rst = 1'b0;
    step(1'b1, 1'b1);
    check("post_release[0]", so8, 1'b0);
    for (int i = 1; i < 7; i++) begin
      step(1'b0, 1'b1);
      check($sformatf("post_release[%0d]", i), so8, 1'b0);
    end
    step(1'b0, 1'b1);
    check("post_release_arrival", so8, 1'b1);
    step(1'b0, 1'b1);
    check("post_release_tail", so8, 1'b0);

    // ---------------- DEPTH = 1 ----------------
    step(1'b1, 1'b1);
    check("depth1[0]", so1, 1'b1);
    step(1'b0, 1'b1);
    check("depth1[1]", so1, 1'b0);
    step(1'b1, 1'b1);
    check("depth1[2]", so1, 1'b1);
    step(1'b0, 1'b0);
    check("depth1_hold", so1, 1'b1);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
